// File: rtl/lp805x_sfrbus_pkg.sv
// Shared definitions for the lp805x SFR bus arbiter: bus widths, command
// field positions, the strobe mask and the sequencer state type.
package lp805x_sfrbus_pkg;

    localparam int SFR_CMD_W = 29;
    localparam int SFR_RSP_W = 9;

    localparam int WR_ADDR_MSB = 28;
    localparam int WR_ADDR_LSB = 21;
    localparam int RD_ADDR_MSB = 20;
    localparam int RD_ADDR_LSB = 13;
    localparam int DATA_IN_MSB = 12;
    localparam int DATA_IN_LSB = 5;
    localparam int F_WR        = 4;
    localparam int F_RD        = 3;
    localparam int F_BIT_IN    = 2;
    localparam int F_WR_BIT    = 1;
    localparam int F_RD_BIT    = 0;

    // Clears wr, rd, bit_in, wr_bit and rd_bit while keeping addresses and data.
    localparam logic [SFR_CMD_W-1:0] STROBE_MASK = 29'h1FFFFFE0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sfr_state_e;

    function automatic logic is_rd_cmd(input logic [SFR_CMD_W-1:0] cmd);
        return cmd[F_RD] | cmd[F_RD_BIT];
    endfunction

endpackage

// File: rtl/lp805x_sfrbus_tick.sv
// Free-running divider for the slow peripheral domain; tick is high on the
// last count of every DIV-cycle period.
module lp805x_sfrbus_tick #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(DIV - 1);

    logic [7:0] tcnt_q;
    logic [7:0] tcnt_d;

    // Next count: wrap to zero after the last count of the period.
    always_comb begin
        if (tcnt_q == LAST) begin
            tcnt_d = 8'd0;
        end else begin
            tcnt_d = tcnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt_q <= 8'd0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign tick = (tcnt_q == LAST);

endmodule

// File: rtl/lp805x_sfrbus_arb.sv
// Round-robin arbiter and sequencer sharing one SFR command/response bus
// between the core (m0) and a debug/DMA master (m1).
module lp805x_sfrbus_arb
    import lp805x_sfrbus_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_req,
    input  logic [SFR_CMD_W-1:0] m0_cmd,
    output logic                 m0_ack,
    output logic [SFR_RSP_W-1:0] m0_rdata,
    input  logic                 m1_req,
    input  logic [SFR_CMD_W-1:0] m1_cmd,
    output logic                 m1_ack,
    output logic [SFR_RSP_W-1:0] m1_rdata,
    output logic [SFR_CMD_W-1:0] sfr_bus,
    output logic                 sfr_load,
    input  logic [SFR_RSP_W-1:0] sfr_rsp
);

    sfr_state_e           state_q, state_d;
    logic [SFR_CMD_W-1:0] cmd_q, cmd_d;
    logic [SFR_CMD_W-1:0] bus_q, bus_d;
    logic                 gnt_q, gnt_d;
    logic                 last_gnt_q, last_gnt_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;
    logic [SFR_RSP_W-1:0] rdata0_q, rdata0_d;
    logic [SFR_RSP_W-1:0] rdata1_q, rdata1_d;
    logic                 tick;

    lp805x_sfrbus_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Sequencer next state; the bus value is computed for the state being entered.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        bus_d      = '0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
                        gnt_d = ~last_gnt_q;
                    end else begin
                        gnt_d = m1_req;
                    end
                    last_gnt_d = gnt_d;
                    cmd_d      = gnt_d ? m1_cmd : m0_cmd;
                    bus_d      = cmd_d;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!tick) begin
                    bus_d = cmd_q;
                end else if (is_rd_cmd(cmd_q)) begin
                    // Hold addresses through WAIT but drop strobes so the next load is inert.
                    bus_d   = cmd_q & STROBE_MASK;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                end
            end
            ST_WAIT: begin
                if (tick) begin
                    state_d = ST_DONE;
                    ack0_d  = ~gnt_q;
                    ack1_d  = gnt_q;
                    if (gnt_q) begin
                        rdata1_d = sfr_rsp;
                    end else begin
                        rdata0_d = sfr_rsp;
                    end
                end else begin
                    bus_d = cmd_q & STROBE_MASK;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            bus_q      <= '0;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            bus_q      <= bus_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign sfr_bus  = bus_q;
    assign sfr_load = tick;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_lp805x_sfrbus_arb.sv
// Bench for lp805x_sfrbus_arb: four instances (DIV=1..4) checked every cycle
// against a transaction-schedule model, plus directed literal expectations.
module tb_lp805x_sfrbus_arb;

    localparam logic [28:0] MASK = 29'h1FFFFFE0;

    logic        clk = 1'b0;
    logic        rst_v      [4];
    logic        m0_req_v   [4];
    logic [28:0] m0_cmd_v   [4];
    logic        m0_ack_v   [4];
    logic [8:0]  m0_rdata_v [4];
    logic        m1_req_v   [4];
    logic [28:0] m1_cmd_v   [4];
    logic        m1_ack_v   [4];
    logic [8:0]  m1_rdata_v [4];
    logic [28:0] sfr_bus_v  [4];
    logic        sfr_load_v [4];
    logic [8:0]  sfr_rsp_v  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        lp805x_sfrbus_arb #(.DIV(g + 1)) u_dut (
            .clk      (clk),
            .rst      (rst_v[g]),
            .m0_req   (m0_req_v[g]),
            .m0_cmd   (m0_cmd_v[g]),
            .m0_ack   (m0_ack_v[g]),
            .m0_rdata (m0_rdata_v[g]),
            .m1_req   (m1_req_v[g]),
            .m1_cmd   (m1_cmd_v[g]),
            .m1_ack   (m1_ack_v[g]),
            .m1_rdata (m1_rdata_v[g]),
            .sfr_bus  (sfr_bus_v[g]),
            .sfr_load (sfr_load_v[g]),
            .sfr_rsp  (sfr_rsp_v[g])
        );
    end

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s [DIV=%0d] cycle %0d: got %0h expected %0h", nm, idx + 1, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: each accepted transaction becomes a schedule of cycles
    // (issue window, wait window, ack cycle, capture cycle).
    int          base  [4];
    bit          busy  [4];
    int          tst   [4];
    int          l1    [4];
    int          ackc  [4];
    int          capc  [4];
    int          gm    [4];
    int          lastg [4];
    bit          mrd   [4];
    logic [28:0] mcmd  [4];
    logic [8:0]  erd   [4][2];
    int rd_load_cnt [4];
    int rdbit_load_cnt [4];
    int strobe_cnt [4];
    int ack1_cnt [4];

    function automatic bit is_load(input int i, input int c);
        return ((c - base[i]) % (i + 1)) == i;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_v[i]) begin
                busy[i]   = 1'b0;
                erd[i][0] = 9'd0;
                erd[i][1] = 9'd0;
                base[i]   = cyc + 1;
                lastg[i]  = 1;
            end else begin
                logic [28:0] ebus;
                logic        ea0;
                logic        ea1;
                int          g;
                ebus = 29'd0;
                ea0  = 1'b0;
                ea1  = 1'b0;
                if (busy[i]) begin
                    if (cyc >= tst[i] + 1 && cyc <= l1[i]) ebus = mcmd[i];
                    else if (mrd[i] && cyc > l1[i] && cyc <= l1[i] + i + 1) ebus = mcmd[i] & MASK;
                    if (cyc == ackc[i]) begin
                        if (gm[i] == 0) ea0 = 1'b1;
                        else ea1 = 1'b1;
                    end
                end
                chk("sfr_load", i, 32'(sfr_load_v[i]), 32'(is_load(i, cyc)));
                chk("sfr_bus",  i, 32'(sfr_bus_v[i]),  32'(ebus));
                chk("m0_ack",   i, 32'(m0_ack_v[i]),   32'(ea0));
                chk("m1_ack",   i, 32'(m1_ack_v[i]),   32'(ea1));
                chk("m0_rdata", i, 32'(m0_rdata_v[i]), 32'(erd[i][0]));
                chk("m1_rdata", i, 32'(m1_rdata_v[i]), 32'(erd[i][1]));
                if (sfr_load_v[i] && sfr_bus_v[i][3]) rd_load_cnt[i]++;
                if (sfr_load_v[i] && sfr_bus_v[i][0]) rdbit_load_cnt[i]++;
                if (sfr_bus_v[i][4:0] != 5'd0) strobe_cnt[i]++;
                if (m1_ack_v[i]) ack1_cnt[i]++;
                if (busy[i]) begin
                    if (mrd[i] && cyc == capc[i]) erd[i][gm[i]] = sfr_rsp_v[i];
                    if (cyc == ackc[i]) busy[i] = 1'b0;
                end else if (m0_req_v[i] || m1_req_v[i]) begin
                    if (m0_req_v[i] && m1_req_v[i]) g = (lastg[i] == 0) ? 1 : 0;
                    else g = m1_req_v[i] ? 1 : 0;
                    lastg[i] = g;
                    gm[i]    = g;
                    mcmd[i]  = (g == 1) ? m1_cmd_v[i] : m0_cmd_v[i];
                    mrd[i]   = mcmd[i][3] | mcmd[i][0];
                    tst[i]   = cyc;
                    l1[i]    = cyc + 1;
                    while (!is_load(i, l1[i])) l1[i]++;
                    capc[i]  = l1[i] + i + 1;
                    ackc[i]  = mrd[i] ? l1[i] + i + 2 : l1[i] + 1;
                    busy[i]  = 1'b1;
                end
            end
        end
    end

    // Called and returning at 1 time unit after a rising edge.
    task automatic run_txn(input int i, input int m, input logic [28:0] cmd, input logic [8:0] rsp,
                           output int lat, output logic [28:0] first_bus);
        bit seen;
        seen = 1'b0;
        lat = -1;
        first_bus = 29'd0;
        if (m == 0) begin m0_cmd_v[i] = cmd; m0_req_v[i] = 1'b1; end
        else begin m1_cmd_v[i] = cmd; m1_req_v[i] = 1'b1; end
        for (int k = 0; k < 40 && !seen; k++) begin
            sfr_rsp_v[i] = sfr_load_v[i] ? rsp : ~rsp;
            @(negedge clk);
            if (k == 1) first_bus = sfr_bus_v[i];
            if ((m == 0) ? m0_ack_v[i] : m1_ack_v[i]) begin
                seen = 1'b1;
                lat = k;
            end
            @(posedge clk); #1;
        end
        m0_req_v[i] = 1'b0;
        m1_req_v[i] = 1'b0;
        m0_cmd_v[i] = 29'd0;
        m1_cmd_v[i] = 29'd0;
        sfr_rsp_v[i] = 9'd0;
        chk("ack_seen", i, 32'(seen), 32'd1);
    endtask

    initial begin
        int          lat;
        logic [28:0] fb;
        logic [28:0] cmd;
        int          order [4];
        int          nord;
        int          both;
        bit          found;

        for (int i = 0; i < 4; i++) begin
            rst_v[i] = 1'b1; m0_req_v[i] = 1'b0; m1_req_v[i] = 1'b0;
            m0_cmd_v[i] = 29'd0; m1_cmd_v[i] = 29'd0; sfr_rsp_v[i] = 9'd0;
            rd_load_cnt[i] = 0; rdbit_load_cnt[i] = 0; strobe_cnt[i] = 0; ack1_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) rst_v[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_bus",  i, 32'(sfr_bus_v[i]), 32'd0);
            chk("rst_ack",  i, 32'({m0_ack_v[i], m1_ack_v[i]}), 32'd0);
            chk("rst_load", i, 32'(sfr_load_v[i]), (i == 0) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;

        // DIV=1 write from m0
        cmd = {8'h90, 8'h00, 8'hA5, 5'b10000};
        run_txn(0, 0, cmd, 9'h000, lat, fb);
        chk("div1_wr_lat", 0, 32'(lat), 32'd2);
        chk("div1_wr_bus", 0, 32'(fb), 32'h1200_14B0);
        chk("div1_rdata",  0, 32'(m0_rdata_v[0]), 32'd0);

        // DIV=4 byte read from m0
        rd_load_cnt[3] = 0; ack1_cnt[3] = 0;
        cmd = {8'h00, 8'h81, 8'h00, 5'b01000};
        run_txn(3, 0, cmd, 9'h15A, lat, fb);
        chk("div4_rd_rdata", 3, 32'(m0_rdata_v[3]), 32'h15A);
        chk("div4_rd_lat",   3, 32'(lat >= 6 && lat <= 9), 32'd1);
        chk("div4_rd_loads", 3, 32'(rd_load_cnt[3]), 32'd1);
        chk("div4_m1_ack",   3, 32'(ack1_cnt[3]), 32'd0);

        // DIV=2 contention, both masters always requesting writes
        m0_cmd_v[1] = {8'hA0, 8'h00, 8'h11, 5'b10000};
        m1_cmd_v[1] = {8'hB0, 8'h00, 8'h22, 5'b10000};
        m0_req_v[1] = 1'b1; m1_req_v[1] = 1'b1;
        for (int k = 0; k < 4; k++) order[k] = -1;
        nord = 0; both = 0;
        for (int k = 0; k < 60 && nord < 4; k++) begin
            @(negedge clk);
            if (m0_ack_v[1] && m1_ack_v[1]) both++;
            if (m0_ack_v[1] && nord < 4) begin order[nord] = 0; nord++; end
            if (m1_ack_v[1] && nord < 4) begin order[nord] = 1; nord++; end
            @(posedge clk); #1;
        end
        m0_req_v[1] = 1'b0; m1_req_v[1] = 1'b0;
        chk("rr_count", 1, 32'(nord), 32'd4);
        chk("rr_g0", 1, 32'(order[0]), 32'd0);
        chk("rr_g1", 1, 32'(order[1]), 32'd1);
        chk("rr_g2", 1, 32'(order[2]), 32'd0);
        chk("rr_g3", 1, 32'(order[3]), 32'd1);
        chk("rr_both", 1, 32'(both), 32'd0);
        repeat (2) @(posedge clk);
        #1;

        // DIV=3 bit read from m1
        rdbit_load_cnt[2] = 0;
        cmd = {8'h00, 8'hD7, 8'h00, 5'b00001};
        run_txn(2, 1, cmd, 9'h001, lat, fb);
        chk("div3_bit_rdata", 2, 32'(m1_rdata_v[2]), 32'h001);
        chk("div3_bit_loads", 2, 32'(rdbit_load_cnt[2]), 32'd1);
        chk("div3_m0_rdata",  2, 32'(m0_rdata_v[2]), 32'd0);

        // DIV=4 reset while waiting on a read
        m0_cmd_v[3] = {8'h00, 8'h85, 8'h00, 5'b01000};
        m0_req_v[3] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (sfr_bus_v[3] != 29'd0 && sfr_bus_v[3][4:0] == 5'd0) found = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst_wait_found", 3, 32'(found), 32'd1);
        rst_v[3] = 1'b1;
        @(posedge clk); #1;
        rst_v[3] = 1'b0;
        m0_req_v[3] = 1'b0;
        m0_cmd_v[3] = 29'd0;
        @(negedge clk);
        chk("mid_rst_bus",    3, 32'(sfr_bus_v[3]), 32'd0);
        chk("mid_rst_acks",   3, 32'({m0_ack_v[3], m1_ack_v[3]}), 32'd0);
        chk("mid_rst_rdata0", 3, 32'(m0_rdata_v[3]), 32'd0);
        chk("mid_rst_rdata1", 3, 32'(m1_rdata_v[3]), 32'd0);
        chk("mid_rst_load",   3, 32'(sfr_load_v[3]), 32'd0);
        @(posedge clk); #1;
        cmd = {8'hC4, 8'h00, 8'h3C, 5'b10000};
        run_txn(3, 0, cmd, 9'h000, lat, fb);
        chk("post_rst_wr_lat", 3, 32'(lat >= 2 && lat <= 5), 32'd1);

        // DIV=2 command with no strobes from m1
        strobe_cnt[1] = 0;
        cmd = {8'h12, 8'h34, 8'h56, 5'b00000};
        run_txn(1, 1, cmd, 9'h1FF, lat, fb);
        chk("nostb_strobes", 1, 32'(strobe_cnt[1]), 32'd0);
        chk("nostb_rdata",   1, 32'(m1_rdata_v[1]), 32'd0);
        chk("nostb_lat",     1, 32'(lat >= 2 && lat <= 3), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
